// File: rtl/bus_uart_tx_pkg.sv
// bus_uart_tx_pkg: register offsets, STATUS bit layout and TX state encoding shared by the UART blocks
package bus_uart_tx_pkg;
    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_CTRL   = 2'd2;
    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 8;
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;
endpackage

// File: rtl/bus_uart_tx_sync_fifo.sv
// bus_uart_tx_sync_fifo: synchronous FIFO; a push into a full FIFO is accepted only alongside a pop
module bus_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic push_ok, pop_ok;
    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        mem_d    = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and RAM-like registered reads
module bus_uart_tx
    import bus_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] dataIn,
    input  logic        busWriteEnable,
    output logic [31:0] dataOut,
    output logic        hit,
    output logic        txd
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
    logic sel, push, pop, clr_ovf, full, empty, baud_done, unused_bits;
    logic [1:0] reg_sel;
    logic [CW-1:0] count;
    logic [7:0] rdata;
    logic [31:0] status;
    logic wr_data_q, wr_data_d, ovf_q, ovf_d, hit_q, hit_d, txd_q, txd_d;
    logic [31:0] data_out_q, data_out_d;
    tx_state_e state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    assign unused_bits = ^{address[1:0], dataIn[31:8]};
    assign dataOut = data_out_q;
    assign hit = hit_q;
    assign txd = txd_q;
    assign baud_done = baud_q == '0;
    bus_uart_tx_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .wdata(dataIn[7:0]),
        .rdata(rdata), .full(full), .empty(empty), .count(count)
    );
    // Only the first cycle of a held DATA store pushes.
    always_comb begin
        sel        = address[31:4] == BASE_ADDR[31:4];
        reg_sel    = address[3:2];
        wr_data_d  = sel & busWriteEnable & (reg_sel == UART_REG_DATA);
        push       = wr_data_d & ~wr_data_q;
        clr_ovf    = sel & busWriteEnable & (reg_sel == UART_REG_CTRL) & dataIn[0];
        ovf_d      = clr_ovf ? 1'b0 : ovf_q | (push & full & ~pop);
        status     = '0;
        status[ST_BUSY]  = state_q != TX_IDLE;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_OVF]   = ovf_q;
        status[ST_CNT_LO +: 4] = 4'(count);
        data_out_d = (sel && reg_sel == UART_REG_STATUS) ? status : '0;
        hit_d      = sel;
    end
    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == TX_IDLE) ? '0 : (baud_done ? BAUD_MAX : baud_q - 1'b1);
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            TX_IDLE: if (!empty) begin
                pop     = 1'b1;
                shift_d = rdata;
                state_d = TX_START;
                baud_d  = BAUD_MAX;
                txd_d   = 1'b0;
            end
            TX_START: if (baud_done) begin
                state_d = TX_DATA;
                bit_d   = '0;
                txd_d   = shift_q[0];
            end
            TX_DATA: if (baud_done) begin
                if (bit_q == 3'd7) begin
                    state_d = TX_STOP;
                    txd_d   = 1'b1;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                    txd_d   = shift_q[1];
                end
            end
            // Popping on the last STOP cycle chains frames without an idle gap.
            TX_STOP: if (baud_done) begin
                pop     = !empty;
                shift_d = rdata;
                state_d = empty ? TX_IDLE : TX_START;
                txd_d   = empty;
            end
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_data_q  <= 1'b0;
            ovf_q      <= 1'b0;
            hit_q      <= 1'b0;
            data_out_q <= '0;
            state_q    <= TX_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            wr_data_q  <= wr_data_d;
            ovf_q      <= ovf_d;
            hit_q      <= hit_d;
            data_out_q <= data_out_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
        end
    end
endmodule

// File: doc/bus_uart_tx.md
# bus_uart_tx

Memory-mapped UART transmitter that sits on the CPU data bus directly downstream of the `CPU` core, next to main memory. It decodes a small register window, accepts bytes from CPU stores into an internal FIFO, and serialises them 8N1 on `txd`. Reads return status with the same one-cycle registered latency as the RAM, so the CPU sees it as ordinary memory.

## Interface
- `BASE_ADDR`, 32'hF000_0000: window base; window is `BASE_ADDR` to `BASE_ADDR+'hF`.
- `CLK_DIV`, 16: clocks per serial bit, ≥2.
- `FIFO_DEPTH`, 8: TX FIFO entries, power of two.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `address`  in  32: CPU bus address.
- `dataIn`  in  32: CPU store data (CPU `dataOut`).
- `busWriteEnable`  in  1: 1 = write, 0 = read.
- `dataOut`  out  32: registered read data to bus mux.
- `hit`  out  1: registered; 1 when last cycle's address was in window (bus mux select).
- `txd`  out  1: serial output, idle high.

## Operation
- Decode: `sel = address[31:4] == BASE_ADDR[31:4]`; register = `address[3:2]`; `address[1:0]` ignored.
- Registers:
  - 0x0 DATA: write pushes `dataIn[7:0]`; read returns 0.
  - 0x4 STATUS (RO): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), [11:8] FIFO count, others 0.
  - 0x8 CTRL: write with `dataIn[0]=1` clears overflow; read returns 0.
  - 0xC: reads 0, writes ignored.
- Reads have no side effects; the CPU drives the bus every cycle.
- Push fires only on the first cycle of a write hit to DATA: `wr_data & ~wr_data_q`. Stores held several cycles push once. Two DATA stores without an intervening non-DATA-write cycle are treated as one; the multi-cycle CPU guarantees a fetch cycle between them.
- Push while full and no pop in the same cycle: byte dropped, overflow set. Push and pop in the same cycle when full: both occur, count unchanged, overflow not set.
- No empty bypass: the FSM pops only when the registered count is nonzero.
- TX FSM: IDLE -> START -> DATA -> STOP -> (IDLE, or START if FIFO non-empty).
  - IDLE: `txd=1`. If not empty, pop into shift register and go to START.
  - START: `txd=0`.
  - DATA: LSB first, 8 bits.
  - STOP: `txd=1`.
  - Each state lasts exactly `CLK_DIV` cycles, timed by a down-counter reloaded with `CLK_DIV-1`.
  - Pop for the next byte occurs on the last STOP cycle, so back-to-back frames have no idle gap.

## Timing
- Reset (async, low): FIFO empty, pointers 0, overflow 0, FSM IDLE, `txd=1`, `dataOut=0`, `hit=0`, `wr_data_q=0`, baud counter 0.
- Read latency: `dataOut` and `hit` are valid 1 cycle after the address is presented, matching RAM.
- Write to empty FIFO with FSM idle:
  - count increments at edge E.
  - Pop and IDLE->START at E+1.
  - `txd` falls at E+1.
- Frame length: 10·`CLK_DIV` cycles.
- STATUS reflects pre-edge state: a read in the same cycle as a push shows the old count.
- Reset asserted mid-frame: `txd` goes high immediately; the queued byte and the partial frame are lost.
- Count width: log2(`FIFO_DEPTH`)+1 bits.
- Pointers: log2(`FIFO_DEPTH`) bits, natural wrap-around.

## Structure
- Shared header `uart_defs.vh`:
  - register offsets (`UART_REG_DATA/STATUS/CTRL`).
  - STATUS bit indices.
  - FSM state encoding (2-bit IDLE/START/DATA/STOP).
- Sub-module `sync_fifo`:
  - parameters WIDTH, DEPTH.
  - ports `clk`, `reset`, push, pop, wdata, rdata, full, empty, count.
  - pop/push rules as above.
- Top module holds the decode, edge detect, register read mux, and the TX FSM with baud counter and bit counter.

## Test plan
- Reset, then read 0xF0000004 → one cycle later `hit=1`, `dataOut=32'h4` (empty), `txd=1`.
- `CLK_DIV=4`, store 0x55 to DATA holding `busWriteEnable` 3 cycles → exactly one frame on `txd`:
  - frame is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles.
  - `txd` falls 1 cycle after the push edge.
  - STATUS busy=1 during the frame, 0 after 40 cycles.
- Push 0xA1 and 0xB2 back-to-back (fetch cycle between) → two frames with no idle cycle between STOP and START. LSB-first bits are checked.
- `FIFO_DEPTH=8`: push 10 bytes while the first frame runs →
  - 1 popped, 8 queued, 1 dropped.
  - STATUS shows full=1, overflow=1, count=8.
  - Write CTRL=1 → overflow=0.
- Assert `reset` low mid-DATA bit 3 → `txd=1` asynchronously. After release, STATUS=32'h4 and no further frame.
- Read 0xF0000010 (outside the window) → `hit=0`. Write to it → FIFO count unchanged.
